// File: rtl/div_share_pkg.sv
// Shared types and helpers for the divider-sharing arbiter: FSM states,
// the all-ones error quotient and the select-width function.
package div_share_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_READY,
        ST_DELIVER
    } div_state_t;

    // Wide enough for any supported WIDTH; users slice the low bits.
    localparam logic [63:0] ALL_ONES = '1;

    // Bits needed to index `value` items, never less than one.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/div_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// scanning cyclically through N_REQ requesters.
module rr_pick
    import div_share_pkg::*;
#(
    parameter int N_REQ = 3,
    localparam int SEL_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] grant_idx,
    output logic             any
);

    logic [N_REQ-1:0] rot;
    logic [SEL_W-1:0] off;
    logic [SEL_W:0]   sum;

    always_comb begin
        // Rotate so that bit 0 is the requester the pointer names.
        rot = N_REQ'({req, req} >> ptr);
        off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = SEL_W'(k);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (SEL_W + 1)'(N_REQ)) begin
            grant_idx = SEL_W'(sum - (SEL_W + 1)'(N_REQ));
        end else begin
            grant_idx = SEL_W'(sum);
        end
        any = |req;
    end

endmodule

// File: rtl/div_share_arbiter.sv
// Round-robin owner of the shared sequential divider. Optional watchdog on
// the divider handshake is enabled with `define DIV_SHARE_TIMEOUT_EN.
module div_share_arbiter
    import div_share_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int WIDTH       = 16,
    parameter int TIMEOUT_CYC = 255,
    localparam int SEL_W      = clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_dividend,
    input  logic [N_REQ*WIDTH-1:0] req_divisor,
    output logic [N_REQ-1:0]       done,
    output logic [WIDTH-1:0]       result,
    output logic                   err,
    output logic                   div_start,
    output logic [WIDTH-1:0]       div_dividend,
    output logic [WIDTH-1:0]       div_divisor,
    output logic [SEL_W-1:0]       div_select,
    input  logic                   div_busy,
    input  logic                   div_ready,
    input  logic [WIDTH-1:0]       div_result
);

    if (N_REQ < 2 || N_REQ > 8 || WIDTH < 1 || WIDTH > 64 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("div_share_arbiter: unsupported parameter set");
    end

    div_state_t       state, state_nxt;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;
    logic             grant_load;
    logic             start_nxt;
    logic             cap_q;
    logic             cap_err;
    logic             to_hit;
    logic             cand_zero;

    logic [WIDTH-1:0] dvd_arr [N_REQ];
    logic [WIDTH-1:0] dvs_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign dvd_arr[g] = req_dividend[g*WIDTH +: WIDTH];
        assign dvs_arr[g] = req_divisor[g*WIDTH +: WIDTH];
    end

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req       (req),
        .ptr       (ptr),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    assign cand_zero = (dvs_arr[pick_idx] == '0);

`ifdef DIV_SHARE_TIMEOUT_EN
    localparam int TO_W = (clog2(TIMEOUT_CYC + 1) > 8) ? clog2(TIMEOUT_CYC + 1) : 8;
    logic [TO_W-1:0] to_cnt;
    logic            waiting;

    assign waiting = (state == ST_ISSUE) || (state == ST_WAIT_BUSY) || (state == ST_WAIT_READY);
    assign to_hit  = waiting && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // Cleared at grant, so it reads zero on the first ISSUE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (grant_load) begin
            to_cnt <= '0;
        end else if (waiting) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        grant_load = 1'b0;
        start_nxt  = 1'b0;
        cap_q      = 1'b0;
        cap_err    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_load = 1'b1;
                    if (cand_zero) begin
                        cap_err   = 1'b1;
                        state_nxt = ST_DELIVER;
                    end else begin
                        state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // Never start while the divider is still busy, e.g. from an
                // operation abandoned by reset.
                if (to_hit) begin
                    cap_err   = 1'b1;
                    state_nxt = ST_DELIVER;
                end else if (!div_busy) begin
                    start_nxt = 1'b1;
                    state_nxt = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (div_ready) begin
                    cap_q     = 1'b1;
                    state_nxt = ST_DELIVER;
                end else if (to_hit) begin
                    cap_err   = 1'b1;
                    state_nxt = ST_DELIVER;
                end else if (div_busy) begin
                    state_nxt = ST_WAIT_READY;
                end
            end
            ST_WAIT_READY: begin
                if (div_ready) begin
                    cap_q     = 1'b1;
                    state_nxt = ST_DELIVER;
                end else if (to_hit) begin
                    cap_err   = 1'b1;
                    state_nxt = ST_DELIVER;
                end
            end
            ST_DELIVER: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr          <= '0;
            div_select   <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            div_start    <= 1'b0;
            result       <= '0;
            err          <= 1'b0;
        end else begin
            div_start <= start_nxt;
            if (grant_load) begin
                div_select   <= pick_idx;
                div_dividend <= dvd_arr[pick_idx];
                div_divisor  <= dvs_arr[pick_idx];
                ptr          <= (pick_idx == SEL_W'(N_REQ - 1)) ? '0 : pick_idx + SEL_W'(1);
            end
            if (cap_q) begin
                result <= div_result;
                err    <= 1'b0;
            end else if (cap_err) begin
                result <= ALL_ONES[WIDTH-1:0];
                err    <= 1'b1;
            end
        end
    end

    always_comb begin
        done = '0;
        if (state == ST_DELIVER) done[div_select] = 1'b1;
    end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Scoreboard bench for div_share_arbiter with a behavioural divider model
// of configurable latency; add DIV_SHARE_TIMEOUT_EN to exercise the watchdog.
module tb_div_share_arbiter;

    localparam int N  = 3;
    localparam int W  = 16;
    localparam int TO = 255;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_dividend, req_divisor;
    logic [N-1:0]   done;
    logic [W-1:0]   result;
    logic           err;
    logic           div_start;
    logic [W-1:0]   div_dividend, div_divisor;
    logic [SW-1:0]  div_select;
    logic           div_busy  = 1'b0;
    logic           div_ready = 1'b0;
    logic [W-1:0]   div_q     = '0;

    logic [W-1:0] op_a [N];
    logic [W-1:0] op_b [N];

    typedef struct {
        int         idx;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic       e;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int mptr = 0;
    int starts_seen = 0;
    int starts_exp = 0;
    bit outstanding = 1'b0;
    int lat_cfg = 2;
    bit hang = 1'b0;
    int dcnt = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_dividend = '0;
        req_divisor  = '0;
        for (int i = 0; i < N; i++) begin
            req_dividend[i*W +: W] = op_a[i];
            req_divisor[i*W +: W]  = op_b[i];
        end
    end

    div_share_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req(req),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .done(done), .result(result), .err(err),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_select(div_select), .div_busy(div_busy), .div_ready(div_ready),
        .div_result(div_q)
    );

    // External divider: not tied to the arbiter reset.
    always @(posedge clk) begin
        div_ready <= 1'b0;
        if (div_start && !div_busy) begin
            div_q <= (div_divisor == '0) ? '1 : div_dividend / div_divisor;
            if (lat_cfg == 0) begin
                div_ready <= 1'b1;
            end else begin
                div_busy <= 1'b1;
                dcnt     <= lat_cfg;
            end
        end else if (div_busy && !hang) begin
            if (dcnt == 1) begin
                div_busy  <= 1'b0;
                div_ready <= 1'b1;
            end
            dcnt <= dcnt - 1;
        end
    end

    // Monitor: compares every done pulse and every start strobe.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && done != '0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: done=%b with nothing expected", done);
                end else begin
                    e = exp_q.pop_front();
                    if (done != N'(1 << e.idx) || result != e.q || err != e.e) begin
                        errors++;
                        $display("FAIL done_value: done=%b result=%h err=%b, want done[%0d] result=%h err=%b",
                                 done, result, err, e.idx, e.q, e.e);
                    end
                end
            end
            if (!rst && div_start) begin
                checks++;
                starts_seen++;
                if (div_busy || outstanding || exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL start_protocol: busy=%b outstanding=%b pending=%0d, want idle divider and one pending op",
                             div_busy, outstanding, exp_q.size());
                end else if (int'(div_select) != exp_q[0].idx || div_dividend != exp_q[0].a ||
                             div_divisor != exp_q[0].b || exp_q[0].b == '0) begin
                    errors++;
                    $display("FAIL start_operands: sel=%0d %h/%h, want sel=%0d %h/%h (nonzero divisor)",
                             div_select, div_dividend, div_divisor, exp_q[0].idx, exp_q[0].a, exp_q[0].b);
                end
                outstanding = 1'b1;
            end
            if (div_ready) outstanding = 1'b0;
        end
    end

    task automatic push_exp(input int i);
        exp_t e;
        e.idx = i;
        e.a   = op_a[i];
        e.b   = op_b[i];
        e.e   = (op_b[i] == '0);
        e.q   = e.e ? '1 : op_a[i] / op_b[i];
        exp_q.push_back(e);
        if (!e.e) starts_exp++;
    endtask

    // Reference round-robin: serve the set in cyclic order from the pointer.
    task automatic plan_batch(input logic [N-1:0] mask);
        int last;
        last = mptr;
        for (int k = 0; k < N; k++) begin
            if (mask[(mptr + k) % N]) begin
                push_exp((mptr + k) % N);
                last = (mptr + k) % N;
            end
        end
        mptr = (last + 1) % N;
    endtask

    task automatic settle_check(input string name);
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || starts_seen != starts_exp) begin
            errors++;
            $display("FAIL %s_drain: pending=%0d starts=%0d, want pending=0 starts=%0d",
                     name, exp_q.size(), starts_seen, starts_exp);
        end
        exp_q.delete();
        starts_exp = starts_seen;
    endtask

    task automatic run_batch(input logic [N-1:0] mask, input bit rand_lat, input string name);
        int n, nd;
        plan_batch(mask);
        req = mask;
        n = 0;
        nd = 0;
        while (req != '0 && n < 400) begin
            @(negedge clk);
            nd += $countones(done);
            req = req & ~done;
            if (rand_lat) lat_cfg = $urandom_range(0, 6);
            n++;
        end
        checks++;
        if (req != '0 || nd != $countones(mask)) begin
            errors++;
            $display("FAIL %s_dones: got %0d dones (req left %b), want %0d", name, nd, req, $countones(mask));
        end
        req = '0;
        settle_check(name);
    endtask

    initial begin
        int n, nd, st0;
        logic [N-1:0] m;
        rst = 1'b1;
        req = '0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done != '0 || result != '0 || err != 1'b0) begin
            errors++;
            $display("FAIL reset_out: done=%b result=%h err=%b, want zeros", done, result, err);
        end
        checks++;
        if (div_start != 1'b0 || div_dividend != '0 || div_divisor != '0 || div_select != '0) begin
            errors++;
            $display("FAIL reset_div: start=%b %h/%h sel=%0d, want zeros", div_start, div_dividend, div_divisor, div_select);
        end
        rst = 1'b0;
        @(negedge clk);

        // All three held: 0,1,2 then 0 again with fresh operands.
        op_a[0] = 16'd100;  op_b[0] = 16'd7;
        op_a[1] = 16'd900;  op_b[1] = 16'd30;
        op_a[2] = 16'd65535; op_b[2] = 16'd255;
        lat_cfg = 2;
        push_exp(0); push_exp(1); push_exp(2);
        req = 3'b111;
        n = 0;
        nd = 0;
        while (nd < 4 && n < 200) begin
            @(negedge clk);
            if (done[0] && nd == 0) begin
                op_a[0] = 16'd4321;
                op_b[0] = 16'd3;
                push_exp(0);
            end
            nd += $countones(done);
            if (nd >= 4) req = '0;
            n++;
        end
        req = '0;
        mptr = 1;
        checks++;
        if (nd != 4) begin
            errors++;
            $display("FAIL held_dones: got %0d, want 4", nd);
        end
        settle_check("held");

        // Single request from 1: 1200/40 on a 4-cycle divider.
        op_a[1] = 16'd1200; op_b[1] = 16'd40;
        lat_cfg = 4;
        run_batch(3'b010, 1'b0, "single");

        // Zero divisor from 2: all-ones with err, divider untouched.
        op_a[2] = 16'd1234; op_b[2] = 16'd0;
        st0 = starts_seen;
        run_batch(3'b100, 1'b0, "divzero");
        checks++;
        if (starts_seen != st0) begin
            errors++;
            $display("FAIL divzero_start: got %0d starts, want 0", starts_seen - st0);
        end

        // Requester 0 drops and scrambles operands right after its grant.
        op_a[0] = 16'd5000; op_b[0] = 16'd7;
        lat_cfg = 5;
        plan_batch(3'b001);
        req = 3'b001;
        repeat (2) @(negedge clk);
        req = '0;
        op_a[0] = 16'd9;
        op_b[0] = 16'd3;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        settle_check("drop");

        for (int b = 0; b < 25; b++) begin
            m = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                op_a[i] = W'($urandom);
                op_b[i] = ($urandom_range(0, 5) == 0) ? '0 :
                          ($urandom_range(0, 1) == 0) ? W'($urandom_range(1, 300)) : W'($urandom);
            end
            run_batch(m, 1'b1, "random");
        end

        // Reset while the divider has about three busy cycles left.
        op_a[1] = 16'd7777; op_b[1] = 16'd11;
        lat_cfg = 8;
        plan_batch(3'b010);
        req = 3'b010;
        n = 0;
        while (!(div_busy && dcnt == 3) && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(div_busy && dcnt == 3)) begin
            errors++;
            $display("FAIL rst_setup: busy=%b dcnt=%0d, want busy with 3 left", div_busy, dcnt);
        end
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        checks++;
        if (done != '0 || err != 1'b0 || div_start != 1'b0 || div_select != '0 || result != '0) begin
            errors++;
            $display("FAIL midrst_out: done=%b err=%b start=%b sel=%0d result=%h, want zeros",
                     done, err, div_start, div_select, result);
        end
        exp_q.delete();
        starts_exp = starts_seen;
        mptr = 0;
        rst = 1'b0;
        op_a[0] = 16'd333; op_b[0] = 16'd9;
        lat_cfg = 3;
        run_batch(3'b001, 1'b0, "after_rst");

`ifdef DIV_SHARE_TIMEOUT_EN
        begin
            exp_t e;
            hang = 1'b1;
            lat_cfg = 4;
            op_a[0] = 16'd100; op_b[0] = 16'd3;
            e.idx = 0; e.a = op_a[0]; e.b = op_b[0]; e.q = '1; e.e = 1'b1;
            exp_q.push_back(e);
            starts_exp++;
            req = 3'b001;
            n = 0;
            nd = 0;
            while (nd == 0 && n < TO + 40) begin
                @(negedge clk);
                nd += $countones(done);
                n++;
            end
            req = '0;
            checks++;
            if (nd != 1 || n < TO - 1 || n > TO + 3) begin
                errors++;
                $display("FAIL timeout_latency: got done after %0d cycles (%0d dones), want about %0d", n, nd, TO);
            end
            settle_check("timeout");
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
